// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and serialises it as
// start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
module uart_tx #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 Tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO  = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
    localparam logic              HAS_PARITY = (PARITY_EN != 0);
    localparam logic              ODD_BIT    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
        return (^data) ^ ODD_BIT;
    endfunction

    state_e                 state_q,  state_d;
    logic [BAUD_W-1:0]      baud_q,   baud_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [DATA_BITS-1:0]   shift_q,  shift_d;
    logic                   parity_q, parity_d;
    logic                   tx_q,     tx_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;
    logic                   bit_end_s;
    logic                   accept_s;

    assign tx_ready  = (state_q == IDLE) && !rst;
    assign accept_s  = tx_valid && tx_ready;
    assign bit_end_s = (baud_q == BAUD_LAST);

    assign Tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        baud_d   = BAUD_ZERO;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        if (state_q == IDLE) begin
            baud_d = BAUD_ZERO;
        end else if (bit_end_s) begin
            baud_d = BAUD_ZERO;
        end else begin
            baud_d = baud_q + BAUD_ONE;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    parity_d = parity_of(tx_data);
                    idx_d    = IDX_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    idx_d   = IDX_ZERO;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        // The index is cleared on exit so it never rolls over inside DATA.
                        idx_d   = IDX_ZERO;
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = IDX_ZERO;
            end
        endcase

        // Line level is decoded from the upcoming state so Tx stays registered.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= BAUD_ZERO;
            idx_q    <= IDX_ZERO;
            shift_q  <= {DATA_BITS{1'b0}};
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that mirrors the existing UART receiver.
- Accepts one parallel byte through a valid/ready handshake and serialises it onto the line as: idle-high, start bit (0), data bits LSB first, optional parity bit, one stop bit (1).
- Default framing (8 data bits, parity slot present, 1 bit per clock) matches the receiver's frame. A loopback of `Tx` into the receiver's `Rx` must deliver the byte.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- CLKS_PER_BIT, 1, clock cycles each serial bit is held on the line; must be ≥1.
- PARITY_EN, 1, 1 = append a parity bit between the data bits and the stop bit; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  requester has data on tx_data.
- tx_ready  output  1  transmitter idle and able to accept a byte.
- Tx  output  1  serial line, registered; idles at 1.
- busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse when the stop bit has completed.

Behaviour:
- One clock domain only. Reset is synchronous and active-high. Every output is driven by a register except tx_ready.
- Reset values: Tx=1, busy=0, tx_done=0, state=IDLE, baud and bit counters=0, shift register=0.
- tx_ready = (state==IDLE) && !rst. It is combinational from state.
- Handshake: a byte is accepted on a posedge where tx_valid && tx_ready.
  - On acceptance, tx_data is latched into the shift register and parity is computed from the latched value.
  - tx_data and tx_valid are don't-care while busy. A tx_valid asserted during a frame is neither queued nor dropped-with-error; it is simply not sampled.
- Parity bit:
  - Even parity: XOR-reduce of the latched data.
  - Odd parity: inverse of the even-parity value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx=1. On handshake go to START; Tx=0 from the next cycle.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index.
    - After bit DATA_BITS-1 completes: go to PARITY if PARITY_EN=1, else go to STOP.
  - PARITY: Tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE. tx_done=1 on the cycle the FSM enters IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Width = max(1, clog2(CLKS_PER_BIT)).
  - With CLKS_PER_BIT=1 the counter is constant 0, so every state lasts exactly one cycle.
- Bit index width = max(1, clog2(DATA_BITS)). It wraps only by leaving DATA; it never rolls over inside DATA.
- Latency and framing:
  - First Tx=0 appears one cycle after the handshake edge.
  - Frame length = (1 + DATA_BITS + PARITY_EN + 1) × CLKS_PER_BIT cycles.
  - Back-to-back: with tx_valid held high, the next handshake occurs on the first IDLE cycle. Consecutive start bits are therefore separated by frame length + 1 cycle, with Tx=1 in the gap cycle.
- busy = 1 from the cycle after the handshake through the last STOP cycle. busy = 0 on the tx_done cycle.
- Reset mid-frame: on the next edge, Tx=1, state=IDLE, busy=0, and no tx_done pulse. The partial frame is abandoned. tx_ready rises in the first cycle rst is low.
- rst and tx_valid high together: reset wins and no byte is accepted.

Test Plan:
- Even parity, CLKS_PER_BIT=1: send 0xA5 → Tx per cycle = 0,1,0,1,0,0,1,0,1,0,1. tx_done pulses once on the cycle after the stop bit; tx_ready is low for 11 cycles.
- Parity variants, 0x01, CLKS_PER_BIT=1:
  - PARITY_ODD=0 → parity slot Tx=1.
  - PARITY_ODD=1 → parity slot Tx=0.
  - PARITY_EN=0 → 10-cycle frame with no parity slot.
- CLKS_PER_BIT=4, send 0x3C → each bit held exactly 4 cycles and busy high for 44 cycles. Data bits appear as 0,0,1,1,1,1,0,0; parity bit = 0.
- Back-to-back: tx_valid held high with 0x55 then 0xAA → two correct frames separated by exactly one idle cycle of Tx=1. tx_valid toggled mid-frame does not alter Tx.
- Reset at data bit 3 of 0xFF → Tx=1 on the next edge, no tx_done, busy=0. A new 0x12 sent afterwards is framed correctly.
- Loopback Tx into the receiver with default parameters, sending 0x00, 0xFF, 0x5A → the receiver's DataOut equals each sent byte.
